// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command-driven front end for an external 32-bit combinational ALU.
// A command arrives over a valid/ready handshake. Its operands come from an
// internal register file, or from an immediate for operand B. The block drives
// the ALU for one cycle, then captures the ALU result and flags. It writes the
// result back to the register file and returns a response over a second
// valid/ready handshake.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op, cmd_rd, cmd_rs1,       operation, destination and source indices,
//   cmd_rs2, cmd_use_imm, cmd_imm  immediate select and immediate value
//   alu_a, alu_b, alu_ctrl         registered ALU operands and operation select
//   alu_result, alu_zero,          ALU result and flags, sampled at the end of EXEC
//   alu_carry, alu_overflow,
//   alu_negative
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_flags            result and {N,Z,C,V} of the completed command
//   flags_q                        status register {N,Z,C,V} of the last command
//   wr_en, wr_addr, wr_data        direct register-file load port
//   busy                           high whenever the FSM is not idle
module alu_cmd_sequencer #(
    parameter int REG_COUNT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_op,
    input  logic [$clog2(REG_COUNT)-1:0] cmd_rd,
    input  logic [$clog2(REG_COUNT)-1:0] cmd_rs1,
    input  logic [$clog2(REG_COUNT)-1:0] cmd_rs2,
    input  logic                         cmd_use_imm,
    input  logic [31:0]                  cmd_imm,
    output logic [31:0]                  alu_a,
    output logic [31:0]                  alu_b,
    output logic [2:0]                   alu_ctrl,
    input  logic [31:0]                  alu_result,
    input  logic                         alu_zero,
    input  logic                         alu_carry,
    input  logic                         alu_overflow,
    input  logic                         alu_negative,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic [3:0]                   rsp_flags,
    output logic [3:0]                   flags_q,
    input  logic                         wr_en,
    input  logic [$clog2(REG_COUNT)-1:0] wr_addr,
    input  logic [31:0]                  wr_data,
    output logic                         busy
);

    localparam int RW = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [31:0]     regs [REG_COUNT];
    logic [RW-1:0]   rd_q;
    logic            accept;
    logic [31:0]     opa;
    logic [31:0]     opb;

    // In RESP a new command can be taken on the same edge as the response
    // handshake. This keeps the throughput at one command per two cycles.
    assign cmd_ready = !reset && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Register 0 is hard-wired to zero. It is never written, and it is also
    // masked here on the read side.
    assign opa = (cmd_rs1 == '0) ? 32'd0 : regs[cmd_rs1];
    assign opb = cmd_use_imm ? cmd_imm : ((cmd_rs2 == '0) ? 32'd0 : regs[cmd_rs2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = EXEC;
            EXEC: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = accept ? EXEC : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The ALU operands are loaded only when a command is accepted. This keeps
    // alu_a/alu_b/alu_ctrl glitch-free, and they hold their value afterwards.
    // Writeback is the last assignment to the register file in this block, so
    // it overrides a direct load to the same index on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            rd_q      <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            flags_q   <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (accept) begin
                alu_a    <= opa;
                alu_b    <= opb;
                alu_ctrl <= cmd_op;
                rd_q     <= cmd_rd;
            end
            if (wr_en && (wr_addr != '0)) begin
                regs[wr_addr] <= wr_data;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_result;
                rsp_flags <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                flags_q   <= {alu_negative, alu_zero, alu_carry, alu_overflow};
                if (rd_q != '0) begin
                    regs[rd_q] <= alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer. A behavioural ALU stub answers
// the DUT's ALU port. A register-file and status model predicts every response
// from the values that were loaded and the commands that were issued.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic        cmd_use_imm;
    logic [31:0] cmd_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_negative;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags_q;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;

    int          checks;
    int          errors;
    logic [31:0] mregs [8];
    logic [3:0]  mflags;

    alu_cmd_sequencer #(.REG_COUNT(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .flags_q(flags_q),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {N,Z,C,V,result}. Carry on subtract means "no borrow".
    function automatic logic [35:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        w = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = {31'd0, a[31]};
            3'd6: r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    logic [35:0] stub_out;
    always_comb begin
        stub_out     = alu_fn(alu_ctrl, alu_a, alu_b);
        alu_result   = stub_out[31:0];
        alu_negative = stub_out[35];
        alu_zero     = stub_out[34];
        alu_carry    = stub_out[33];
        alu_overflow = stub_out[32];
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mflags = '0;
    endtask

    // Predicts one command's response and applies its writeback to the model.
    task automatic model_exec(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic use_imm, input logic [31:0] imm,
                              output logic [31:0] data, output logic [3:0] flags);
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] o;
        a = (rs1 == 3'd0) ? 32'd0 : mregs[rs1];
        b = use_imm ? imm : ((rs2 == 3'd0) ? 32'd0 : mregs[rs2]);
        o = alu_fn(op, a, b);
        data  = o[31:0];
        flags = o[35:32];
        if (rd != 3'd0) mregs[rd] = data;
        mflags = flags;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
        wr_en = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (addr != 3'd0) mregs[addr] = data;
    endtask

    // Presents a command and returns #1 after the edge that accepts it.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic use_imm, input logic [31:0] imm);
        bit got;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rd = rd;
        cmd_rs1 = rs1;
        cmd_rs2 = rs2;
        cmd_use_imm = use_imm;
        cmd_imm = imm;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue_timeout cmd_ready=%b expected 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    // Waits for the response, counting falling edges, then completes the handshake.
    task automatic collect(output logic [31:0] data, output logic [3:0] flags, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        data = 'x;
        flags = 'x;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_timeout rsp_valid=%b expected 1", rsp_valid);
        end else begin
            data = rsp_data;
            flags = rsp_flags;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [31:0] val);
        logic [31:0] d;
        logic [3:0]  f;
        int          l;
        issue(3'd3, 3'd0, idx, 3'd0, 1'b1, 32'd0);
        model_exec(3'd3, 3'd0, idx, 3'd0, 1'b1, 32'd0, d, f);
        collect(val, f, l);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cmd_ready got=%b exp=0", cmd_ready);
        end
        cmd_valid = 1'b0;
        model_reset();
        checks++;
        if ({rsp_valid, busy, flags_q, rsp_flags, rsp_data, alu_a, alu_b, alu_ctrl} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs valid=%b busy=%b fq=%h rf=%h rd=%h a=%h b=%h c=%h exp all 0",
                     rsp_valid, busy, flags_q, rsp_flags, rsp_data, alu_a, alu_b, alu_ctrl);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_add();
        logic [31:0] d, ed, v;
        logic [3:0]  f, ef;
        int          l;
        write_reg(3'd1, 32'd5);
        write_reg(3'd2, 32'd3);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        model_exec(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, ed, ef);
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_ctrl, busy, rsp_valid} !== {32'd5, 32'd3, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_exec a=%h b=%h ctrl=%h busy=%b valid=%b exp 5 3 0 1 0",
                     alu_a, alu_b, alu_ctrl, busy, rsp_valid);
        end
        collect(d, f, l);
        checks++;
        if (d !== 32'd8 || f !== 4'b0000 || d !== ed || f !== ef) begin
            errors++;
            $display("[TB] FAIL add_rsp data=%h flags=%b exp 8 0000", d, f);
        end
        checks++;
        if (l !== 1) begin
            errors++;
            $display("[TB] FAIL add_latency got=%0d exp=1 more falling edge", l);
        end
        read_reg(3'd3, v);
        checks++;
        if (v !== 32'd8) begin
            errors++;
            $display("[TB] FAIL add_writeback reg3=%h exp 8", v);
        end
    endtask

    task automatic test_flags();
        logic [31:0] d, ed;
        logic [3:0]  f, ef;
        int          l;
        write_reg(3'd1, 32'd3);
        issue(3'd1, 3'd5, 3'd1, 3'd0, 1'b1, 32'd3);
        model_exec(3'd1, 3'd5, 3'd1, 3'd0, 1'b1, 32'd3, ed, ef);
        collect(d, f, l);
        checks++;
        if (d !== 32'd0 || f !== 4'b0110 || flags_q !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL sub_zero data=%h flags=%b flags_q=%b exp 0 0110 0110", d, f, flags_q);
        end
        write_reg(3'd1, 32'h7FFF_FFFF);
        issue(3'd0, 3'd5, 3'd1, 3'd0, 1'b1, 32'd1);
        model_exec(3'd0, 3'd5, 3'd1, 3'd0, 1'b1, 32'd1, ed, ef);
        collect(d, f, l);
        checks++;
        if (d !== 32'h8000_0000 || f !== 4'b1001 || flags_q !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL add_overflow data=%h flags=%b flags_q=%b exp 80000000 1001 1001", d, f, flags_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ea, eb;
        logic [3:0]  f, fa, fb;
        int          l;
        bit          got;
        write_reg(3'd1, 32'd10);
        write_reg(3'd2, 32'd20);
        issue(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        model_exec(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0, ea, fa);
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_rd = 3'd5;
        cmd_rs1 = 3'd3;
        cmd_rs2 = 3'd0;
        cmd_use_imm = 1'b1;
        cmd_imm = 32'd7;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            checks++;
            if (cmd_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_exec_ready got=%b exp=0", cmd_ready);
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL b2b_rsp_timeout rsp_valid=%b exp 1", rsp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_data !== ea || rsp_flags !== fa || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_hold data=%h flags=%b ready=%b valid=%b exp %h %b 0 1",
                         rsp_data, rsp_flags, cmd_ready, rsp_valid, ea, fa);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready got=%b exp=1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second_accept valid=%b busy=%b exp 0 1", rsp_valid, busy);
        end
        model_exec(3'd1, 3'd5, 3'd3, 3'd0, 1'b1, 32'd7, eb, fb);
        collect(d, f, l);
        checks++;
        if (d !== eb || f !== fb || d !== 32'd23) begin
            errors++;
            $display("[TB] FAIL b2b_second data=%h flags=%b exp %h %b", d, f, eb, fb);
        end
    endtask

    task automatic test_reg0();
        logic [31:0] d, ed, v;
        logic [3:0]  f, ef;
        int          l;
        write_reg(3'd1, 32'h1234_5678);
        issue(3'd4, 3'd0, 3'd1, 3'd0, 1'b1, 32'hFF);
        model_exec(3'd4, 3'd0, 3'd1, 3'd0, 1'b1, 32'hFF, ed, ef);
        collect(d, f, l);
        checks++;
        if (d !== 32'h1234_5687) begin
            errors++;
            $display("[TB] FAIL reg0_rsp data=%h exp 12345687", d);
        end
        write_reg(3'd0, 32'hDEAD_BEEF);
        read_reg(3'd0, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reg0_read reg0=%h exp 0", v);
        end
    endtask

    task automatic test_wr_conflict();
        logic [31:0] d, ed, v;
        logic [3:0]  f, ef;
        int          l;
        write_reg(3'd1, 32'd100);
        wr_en = 1'b1;
        wr_addr = 3'd1;
        wr_data = 32'd777;
        issue(3'd0, 3'd6, 3'd1, 3'd0, 1'b1, 32'd5);
        wr_en = 1'b0;
        model_exec(3'd0, 3'd6, 3'd1, 3'd0, 1'b1, 32'd5, ed, ef);
        mregs[1] = 32'd777;
        wr_en = 1'b1;
        wr_addr = 3'd6;
        wr_data = 32'hBAD;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        collect(d, f, l);
        checks++;
        if (d !== 32'd105) begin
            errors++;
            $display("[TB] FAIL conflict_old_operand data=%h exp 105", d);
        end
        read_reg(3'd6, v);
        checks++;
        if (v !== 32'd105) begin
            errors++;
            $display("[TB] FAIL conflict_writeback_wins reg6=%h exp 105", v);
        end
        read_reg(3'd1, v);
        checks++;
        if (v !== 32'd777) begin
            errors++;
            $display("[TB] FAIL conflict_load reg1=%h exp 777", v);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, ed, imm;
        logic [3:0]  f, ef;
        logic [2:0]  op, rd, rs1, rs2;
        logic        ui;
        int          l;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) write_reg(3'($urandom), $urandom);
            op  = 3'($urandom);
            rd  = 3'($urandom);
            rs1 = 3'($urandom);
            rs2 = 3'($urandom);
            ui  = 1'($urandom);
            imm = $urandom;
            issue(op, rd, rs1, rs2, ui, imm);
            model_exec(op, rd, rs1, rs2, ui, imm, ed, ef);
            collect(d, f, l);
            checks++;
            if (d !== ed || f !== ef || flags_q !== mflags || l !== 2) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%0d data=%h flags=%b fq=%b lat=%0d exp %h %b %b 2",
                         i, op, d, f, flags_q, l, ed, ef, mflags);
            end
        end
        for (int r = 1; r < 8; r++) begin
            logic [31:0] v;
            logic [31:0] e;
            e = mregs[r];
            read_reg(3'(r), v);
            checks++;
            if (v !== e) begin
                errors++;
                $display("[TB] FAIL random_reg%0d got=%h exp=%h", r, v, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, ed, v;
        logic [3:0]  f, ef;
        int          l;
        bit          got;
        write_reg(3'd1, 32'd1);
        write_reg(3'd2, 32'd2);
        issue(3'd1, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0);
        model_exec(3'd1, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0, ed, ef);
        collect(d, f, l);
        issue(3'd0, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || flags_q !== 4'b0000 || cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_exec valid=%b busy=%b fq=%b ready=%b exp 0 0 0000 0",
                     rsp_valid, busy, flags_q, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        read_reg(3'd4, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_no_writeback reg4=%h exp 0", v);
        end
        write_reg(3'd1, 32'd1);
        issue(3'd1, 3'd4, 3'd0, 3'd1, 1'b0, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || flags_q !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL resp_before_reset valid=%b fq=%b exp 1 1000", rsp_valid, flags_q);
        end
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (rsp_valid !== 1'b0 || flags_q !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp valid=%b fq=%b busy=%b exp 0 0000 0", rsp_valid, flags_q, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        read_reg(3'd4, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_resp_reg4 reg4=%h exp 0", v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_rd = '0;
        cmd_rs1 = '0;
        cmd_rs2 = '0;
        cmd_use_imm = 1'b0;
        cmd_imm = '0;
        rsp_ready = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        test_reset();
        test_add();
        test_flags();
        test_back_to_back();
        test_reg0();
        test_wr_conflict();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
